conv_out_writer: RTL

- Receiving end of the conv-unit output stream. It consumes the per-cycle output bundle (Conv_data_out / Conv_data_valid_out), buffers it in an internal FIFO, and generates a linear feature-map write address for each bundle.
- It drives a ready/valid write port toward the feature-map buffer.
- The conv stream has no backpressure, so the block absorbs downstream stalls in its FIFO and flags any loss.

---
 rtl/conv_out_writer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/conv_out_writer.sv
// Conv-unit output writer: buffers output bundles in a FIFO and writes them with linear addresses.
// Optional macro CONV_WR_RELU_EN clamps negative lanes to zero before buffering.
module conv_out_writer #(
    parameter int CONV_OUT_NUM = 18,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CONV_OUT_NUM*DATA_WIDTH-1:0] Conv_data_in,
    input  logic                               Conv_data_valid_in,
    input  logic                               frame_start,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [ADDR_WIDTH-1:0]              frame_len,
    output logic [CONV_OUT_NUM*DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0]              wr_addr,
    output logic                               wr_valid,
    input  logic                               wr_ready,
    output logic                               frame_done,
    output logic                               overflow,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);

    localparam int DW = CONV_OUT_NUM * DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] index;

    logic [DW-1:0]         mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         count;

    logic          empty;
    logic          full;
    logic          pop;
    logic          in_valid;
    logic          push;
    logic          drop;
    logic [DW-1:0] push_data;

    // Write port: valid on wr_valid, transfer on wr_valid && wr_ready; head holds while stalled.
    assign empty    = (count == '0);
    assign full     = (count == LW'(FIFO_DEPTH));
    assign pop      = !empty && wr_ready;
    assign in_valid = (state == RUN) && Conv_data_valid_in;
    assign push     = in_valid && (!full || pop);
    assign drop     = in_valid && !push;

    always_comb begin
        push_data = Conv_data_in;
`ifdef CONV_WR_RELU_EN
        for (int k = 0; k < CONV_OUT_NUM; k++) begin
            if (Conv_data_in[k*DATA_WIDTH + DATA_WIDTH - 1]) begin
                push_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
`endif
    end

    // Storage needs no reset: nothing is presented unless count says the slot is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_addr[wr_ptr] <= base_q + index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            index      <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (drop) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        overflow <= 1'b0;
                        if (frame_len != '0) begin
                            state  <= RUN;
                            base_q <= base_addr;
                            len_q  <= frame_len;
                            index  <= '0;
                        end else begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Index advances even on a dropped bundle so later addresses stay aligned.
                    if (Conv_data_valid_in) begin
                        index <= index + ADDR_WIDTH'(1);
                        if (index == len_q - ADDR_WIDTH'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_valid   = !empty;
    assign wr_data    = empty ? '0 : mem_data[rd_ptr];
    assign wr_addr    = empty ? '0 : mem_addr[rd_ptr];
    assign busy       = (state != IDLE);
    assign fifo_level = count;

endmodule
